// File: rtl/fractal_sync_pkg.sv
// Shared request types and port tags for the fractal sync node.
// Used by both the rx (request) and tx (response) datapaths.
package fractal_sync_pkg;

  localparam int unsigned AGGR_W = 8;
  localparam int unsigned ID_W   = 8;
  localparam int unsigned SRC_W  = 4;
  localparam int unsigned TAG_W  = 2;

  localparam logic [TAG_W-1:0] EN_TAG = 2'b01;
  localparam logic [TAG_W-1:0] WS_TAG = 2'b10;

  typedef enum logic {
    PRIO_EN = 1'b0,
    PRIO_WS = 1'b1
  } prio_e;

  typedef struct packed {
    logic              sync;
    logic [AGGR_W-1:0] aggr;
    logic [ID_W-1:0]   id;
    logic [SRC_W-1:0]  src;
  } req_in_t;

  typedef struct packed {
    logic                    sync;
    logic [AGGR_W-1:0]       aggr;
    logic [ID_W-1:0]         id;
    logic [SRC_W+TAG_W-1:0]  src;
  } req_out_t;

endpackage

// File: rtl/fractal_sync_fifo.sv
// Small synchronous FIFO with optional combinational head.
// A push into a full FIFO is dropped even if a pop happens alongside.
module fractal_sync_fifo
  import fractal_sync_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 1,
  parameter type         fifo_t     = logic,
  parameter bit          COMB_OUT   = 1'b1
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  fifo_t data_i,
  input  logic  pop_i,
  output fifo_t data_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int unsigned PW =
    (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);

  fifo_t         mem [FIFO_DEPTH];
  logic [PW-1:0] rd;
  logic [PW-1:0] wr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt == CW'(FIFO_DEPTH));
  assign empty_o = (cnt == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd  <= '0;
      wr  <= '0;
      cnt <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr] <= data_i;
        wr      <= (wr == LAST) ? '0 : wr + 1'b1;
      end
      if (do_pop) begin
        rd <= (rd == LAST) ? '0 : rd + 1'b1;
      end
      if (do_push && !do_pop) begin
        cnt <= cnt + 1'b1;
      end else if (!do_push && do_pop) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  if (COMB_OUT) begin : g_comb_out
    assign data_o = mem[rd];
  end else begin : g_reg_out
    fifo_t head_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        head_q <= '0;
      end else begin
        head_q <= mem[rd];
      end
    end
    assign data_o = head_q;
  end

endmodule

// File: rtl/fractal_sync_rx.sv
// Request-side datapath: per-port FIFOs for en/ws children,
// round-robin merged into one source-tagged request stream.
module fractal_sync_rx
  import fractal_sync_pkg::*;
#(
  parameter type         fsync_req_in_t  = req_in_t,
  parameter type         fsync_req_out_t = req_out_t,
  parameter bit          COMB_IN         = 1'b0,
  parameter int unsigned FIFO_DEPTH      = 1
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  fsync_req_in_t  en_req_i,
  input  fsync_req_in_t  ws_req_i,
  output logic           en_error_overflow_o,
  output logic           ws_error_overflow_o,
  output logic           empty_o,
  output fsync_req_out_t req_o,
  input  logic           pop_i
);

  if (FIFO_DEPTH == 0) begin : g_bad_depth
    $error("fractal_sync_rx: FIFO_DEPTH must be > 0");
  end

  if ($bits(req_o.src) != $bits(en_req_i.src) + 2) begin : g_bad_src
    $error("fractal_sync_rx: output src must be input src + 2 bits");
  end

  fsync_req_in_t  en_smp;
  fsync_req_in_t  ws_smp;
  logic           en_push_q;
  logic           ws_push_q;
  fsync_req_out_t en_tag;
  fsync_req_out_t ws_tag;
  fsync_req_out_t en_head;
  fsync_req_out_t ws_head;
  logic           en_full;
  logic           ws_full;
  logic           en_empty;
  logic           ws_empty;
  logic           en_valid;
  logic           ws_valid;
  logic           sel_ws;
  logic           do_pop;
  logic           en_pop;
  logic           ws_pop;
  prio_e          prio;

  if (COMB_IN) begin : g_comb_in
    assign en_smp    = en_req_i;
    assign ws_smp    = ws_req_i;
    assign en_push_q = en_req_i.sync;
    assign ws_push_q = ws_req_i.sync;
  end else begin : g_reg_in
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        en_smp    <= '0;
        ws_smp    <= '0;
        en_push_q <= 1'b0;
        ws_push_q <= 1'b0;
      end else begin
        if (en_req_i.sync) begin
          en_smp <= en_req_i;
        end
        if (ws_req_i.sync) begin
          ws_smp <= ws_req_i;
        end
        en_push_q <= en_req_i.sync;
        ws_push_q <= ws_req_i.sync;
      end
    end
  end

  // Origin tag lives in the two LSBs so downstream strips it by >> 2.
  always_comb begin
    en_tag      = '0;
    en_tag.sync = en_smp.sync;
    en_tag.aggr = en_smp.aggr;
    en_tag.id   = en_smp.id;
    en_tag.src  = {en_smp.src, EN_TAG};
    ws_tag      = '0;
    ws_tag.sync = ws_smp.sync;
    ws_tag.aggr = ws_smp.aggr;
    ws_tag.id   = ws_smp.id;
    ws_tag.src  = {ws_smp.src, WS_TAG};
  end

  fractal_sync_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .fifo_t     (fsync_req_out_t),
    .COMB_OUT   (1'b1)
  ) u_en_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (en_push_q),
    .data_i  (en_tag),
    .pop_i   (en_pop),
    .data_o  (en_head),
    .full_o  (en_full),
    .empty_o (en_empty)
  );

  fractal_sync_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .fifo_t     (fsync_req_out_t),
    .COMB_OUT   (1'b1)
  ) u_ws_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (ws_push_q),
    .data_i  (ws_tag),
    .pop_i   (ws_pop),
    .data_o  (ws_head),
    .full_o  (ws_full),
    .empty_o (ws_empty)
  );

  assign en_error_overflow_o = en_push_q & en_full;
  assign ws_error_overflow_o = ws_push_q & ws_full;

  assign en_valid = ~en_empty;
  assign ws_valid = ~ws_empty;

  always_comb begin
    sel_ws = 1'b0;
    unique case (1'b1)
      en_valid && ws_valid:  sel_ws = (prio == PRIO_WS);
      ws_valid && !en_valid: sel_ws = 1'b1;
      default:               sel_ws = 1'b0;
    endcase
  end

  assign empty_o = ~(en_valid | ws_valid);
  assign req_o   = sel_ws ? ws_head : en_head;
  assign do_pop  = pop_i & ~empty_o;
  assign en_pop  = do_pop & ~sel_ws;
  assign ws_pop  = do_pop & sel_ws;

  // After a pop the other port gets priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio <= PRIO_EN;
    end else if (do_pop) begin
      prio <= sel_ws ? PRIO_EN : PRIO_WS;
    end
  end

endmodule

// File: tb/tb_fractal_sync_rx.sv
// Directed bench: A = registered inputs, depth 4; B = comb inputs, depth 2.
// Inputs change on negedge; outputs sampled at negedge or #1 after.
module tb_fractal_sync_rx;
  import fractal_sync_pkg::*;

  logic     clk;
  logic     rst_n;
  req_in_t  a_en, a_ws, b_en, b_ws;
  logic     a_pop, b_pop;
  logic     a_en_err, a_ws_err, b_en_err, b_ws_err;
  logic     a_empty, b_empty;
  req_out_t a_req, b_req;

  int vectors;
  int miscompares;

  fractal_sync_rx #(
    .COMB_IN    (1'b0),
    .FIFO_DEPTH (4)
  ) dut_a (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .en_req_i            (a_en),
    .ws_req_i            (a_ws),
    .en_error_overflow_o (a_en_err),
    .ws_error_overflow_o (a_ws_err),
    .empty_o             (a_empty),
    .req_o               (a_req),
    .pop_i               (a_pop)
  );

  fractal_sync_rx #(
    .COMB_IN    (1'b1),
    .FIFO_DEPTH (2)
  ) dut_b (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .en_req_i            (b_en),
    .ws_req_i            (b_ws),
    .en_error_overflow_o (b_en_err),
    .ws_error_overflow_o (b_ws_err),
    .empty_o             (b_empty),
    .req_o               (b_req),
    .pop_i               (b_pop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic req_in_t mk(input logic [7:0] id,
                                 input logic [3:0] src);
    mk      = '0;
    mk.sync = 1'b1;
    mk.id   = id;
    mk.src  = src;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    a_en = '0; a_ws = '0; b_en = '0; b_ws = '0;
    a_pop = 1'b0; b_pop = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (a_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_empty_a got %b exp 1", a_empty);
    end
    vectors++;
    if (a_req !== '0) begin
      miscompares++;
      $display("FAIL reset_req_a got %h exp 0", a_req);
    end
    vectors++;
    if ({a_en_err, a_ws_err, b_en_err, b_ws_err} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_errs got %b exp 0000",
               {a_en_err, a_ws_err, b_en_err, b_ws_err});
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (b_empty !== 1'b1 || b_req !== '0) begin
      miscompares++;
      $display("FAIL idle_b got empty=%b req=%h exp 1/0", b_empty, b_req);
    end
  endtask

  task automatic test_single();
    a_en      = mk(8'd5, 4'd2);
    a_en.aggr = 8'd3;
    @(negedge clk);
    a_en = '0;
    vectors++;
    if (a_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL single_edge1 got empty=%b exp 1", a_empty);
    end
    @(negedge clk);
    vectors++;
    if (a_empty !== 1'b0 || a_req.src !== 6'b001001 ||
        a_req.aggr !== 8'd3 || a_req.id !== 8'd5) begin
      miscompares++;
      $display("FAIL single_edge2 got e=%b src=%b aggr=%0d id=%0d exp 0/001001/3/5",
               a_empty, a_req.src, a_req.aggr, a_req.id);
    end
    a_pop = 1'b1;
    @(negedge clk);
    a_pop = 1'b0;
    vectors++;
    if (a_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL single_pop got empty=%b exp 1", a_empty);
    end
    b_en = mk(8'd7, 4'd1);
    @(negedge clk);
    b_en = '0;
    vectors++;
    if (b_empty !== 1'b0 || b_req.id !== 8'd7 || b_req.src !== 6'b000101) begin
      miscompares++;
      $display("FAIL comb_latency got e=%b id=%0d src=%b exp 0/7/000101",
               b_empty, b_req.id, b_req.src);
    end
    b_pop = 1'b1;
    @(negedge clk);
    b_pop = 1'b0;
  endtask

  task automatic test_both_ports();
    do_reset();
    a_en = mk(8'd1, 4'd0);
    a_ws = mk(8'd2, 4'd0);
    @(negedge clk);
    a_en = '0; a_ws = '0;
    @(negedge clk);
    vectors++;
    if (a_empty !== 1'b0 || a_req.id !== 8'd1 || a_req.src !== 6'b000001) begin
      miscompares++;
      $display("FAIL both_first got e=%b id=%0d src=%b exp 0/1/000001",
               a_empty, a_req.id, a_req.src);
    end
    a_pop = 1'b1;
    @(negedge clk);
    vectors++;
    if (a_empty !== 1'b0 || a_req.id !== 8'd2 || a_req.src !== 6'b000010) begin
      miscompares++;
      $display("FAIL both_second got e=%b id=%0d src=%b exp 0/2/000010",
               a_empty, a_req.id, a_req.src);
    end
    @(negedge clk);
    a_pop = 1'b0;
    vectors++;
    if (a_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL both_drained got empty=%b exp 1", a_empty);
    end
  endtask

  task automatic test_fairness();
    logic [7:0] exp_id [6];
    exp_id = '{8'd10, 8'd20, 8'd11, 8'd21, 8'd12, 8'd22};
    for (int i = 0; i < 3; i++) begin
      a_en = mk(8'(10 + i), 4'd0);
      a_ws = mk(8'(20 + i), 4'd0);
      @(negedge clk);
    end
    a_en = '0; a_ws = '0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (a_empty !== 1'b0 || a_req.id !== exp_id[i]) begin
        miscompares++;
        $display("FAIL fair_order[%0d] got e=%b id=%0d exp 0/%0d",
                 i, a_empty, a_req.id, exp_id[i]);
      end
      a_pop = 1'b1;
      @(negedge clk);
    end
    a_pop = 1'b0;
    vectors++;
    if (a_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL fair_drained got empty=%b exp 1", a_empty);
    end
  endtask

  task automatic test_overflow();
    logic exp_err [3];
    exp_err = '{1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      b_ws = mk(8'(31 + i), 4'd0);
      #1;
      vectors++;
      if (b_ws_err !== exp_err[i] || b_en_err !== 1'b0) begin
        miscompares++;
        $display("FAIL ovf_err[%0d] got ws=%b en=%b exp %b/0",
                 i, b_ws_err, b_en_err, exp_err[i]);
      end
      @(negedge clk);
    end
    b_ws = '0;
    #1;
    vectors++;
    if (b_ws_err !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_err_clear got %b exp 0", b_ws_err);
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (b_empty !== 1'b0 || b_req.id !== 8'(31 + i)) begin
        miscompares++;
        $display("FAIL ovf_keep[%0d] got e=%b id=%0d exp 0/%0d",
                 i, b_empty, b_req.id, 31 + i);
      end
      b_pop = 1'b1;
      @(negedge clk);
    end
    b_pop = 1'b0;
    vectors++;
    if (b_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_dropped got empty=%b exp 1", b_empty);
    end
  endtask

  task automatic test_full_push_pop();
    b_ws = mk(8'd41, 4'd0);
    @(negedge clk);
    b_ws = mk(8'd42, 4'd0);
    @(negedge clk);
    b_ws  = mk(8'd43, 4'd0);
    b_pop = 1'b1;
    #1;
    vectors++;
    if (b_ws_err !== 1'b1 || b_req.id !== 8'd41) begin
      miscompares++;
      $display("FAIL full_pp_err got err=%b id=%0d exp 1/41", b_ws_err, b_req.id);
    end
    @(negedge clk);
    b_ws  = '0;
    b_pop = 1'b0;
    vectors++;
    if (b_empty !== 1'b0 || b_req.id !== 8'd42) begin
      miscompares++;
      $display("FAIL full_pp_occ got e=%b id=%0d exp 0/42", b_empty, b_req.id);
    end
    b_pop = 1'b1;
    @(negedge clk);
    b_pop = 1'b0;
    vectors++;
    if (b_empty !== 1'b1) begin
      miscompares++;
      $display("FAIL full_pp_drop got empty=%b exp 1", b_empty);
    end
    b_en = mk(8'd51, 4'd0);
    @(negedge clk);
    b_en  = '0;
    b_pop = 1'b1;
    @(negedge clk);
    @(negedge clk);
    b_pop = 1'b0;
    vectors++;
    if (b_empty !== 1'b1 || b_en_err !== 1'b0 || b_ws_err !== 1'b0) begin
      miscompares++;
      $display("FAIL empty_pop got e=%b errs=%b%b exp 1/00",
               b_empty, b_en_err, b_ws_err);
    end
    b_en = mk(8'd52, 4'd0);
    b_ws = mk(8'd53, 4'd0);
    @(negedge clk);
    b_en = '0; b_ws = '0;
    vectors++;
    if (b_req.id !== 8'd53 || b_req.src !== 6'b000010) begin
      miscompares++;
      $display("FAIL prio_kept got id=%0d src=%b exp 53/000010",
               b_req.id, b_req.src);
    end
    b_pop = 1'b1;
    @(negedge clk);
    vectors++;
    if (b_req.id !== 8'd52 || b_req.src !== 6'b000001) begin
      miscompares++;
      $display("FAIL prio_next got id=%0d src=%b exp 52/000001",
               b_req.id, b_req.src);
    end
    @(negedge clk);
    b_pop = 1'b0;
  endtask

  task automatic test_reset_mid();
    a_en = mk(8'd61, 4'd0);
    @(negedge clk);
    a_en = mk(8'd62, 4'd0);
    @(negedge clk);
    a_en = '0;
    @(negedge clk);
    vectors++;
    if (a_empty !== 1'b0 || a_req.id !== 8'd61) begin
      miscompares++;
      $display("FAIL mid_queued got e=%b id=%0d exp 0/61", a_empty, a_req.id);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (a_empty !== 1'b1 || a_req !== '0) begin
      miscompares++;
      $display("FAIL mid_async got e=%b req=%h exp 1/0", a_empty, a_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (a_empty !== 1'b1 || a_en_err !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_no_stale got e=%b err=%b exp 1/0", a_empty, a_en_err);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_both_ports();
    test_fairness();
    test_overflow();
    test_full_push_pop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
